// File: rtl/pulse_stretcher_mc.sv
// Multi-channel pulse stretcher: each channel turns a rising edge on its input
// into a registered pulse of a programmable length, then emits a one-cycle done.
module pulse_stretcher_mc #(
    parameter int unsigned CH    = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    pin,
    input  logic [CNT_W-1:0] stretch_len,
    input  logic             retrig,
    output logic [CH-1:0]    pout,
    output logic [CH-1:0]    done,
    output logic             busy
);

    logic [CH-1:0]             pin_d;
    logic [CH-1:0]             rise;
    logic [CNT_W-1:0]          l_eff;
    logic [CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH-1:0]             pout_q, pout_d;
    logic [CH-1:0]             done_q, done_d;

    // A zero length would otherwise never assert the output; treat it as one cycle.
    assign l_eff = (stretch_len == '0) ? CNT_W'(1) : stretch_len;
    assign rise  = pin & ~pin_d;

    // Per-channel next state: load on trigger, count down, pulse done on expiry.
    always_comb begin
        cnt_d  = cnt_q;
        pout_d = pout_q;
        done_d = '0;
        for (int i = 0; i < int'(CH); i++) begin
            if (cnt_q[i] == '0) begin
                if (rise[i]) begin
                    cnt_d[i]  = l_eff;
                    pout_d[i] = 1'b1;
                end
            end else if (rise[i] && retrig) begin
                // Restart the full window; the interrupted window gets no done.
                cnt_d[i]  = l_eff;
                pout_d[i] = 1'b1;
            end else if (cnt_q[i] == CNT_W'(1)) begin
                cnt_d[i]  = '0;
                pout_d[i] = 1'b0;
                done_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // State registers; reset drops every output immediately without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pin_d  <= '0;
            cnt_q  <= '0;
            pout_q <= '0;
            done_q <= '0;
        end else begin
            pin_d  <= pin;
            cnt_q  <= cnt_d;
            pout_q <= pout_d;
            done_q <= done_d;
        end
    end

    assign pout = pout_q;
    assign done = done_q;
    assign busy = |pout_q;

endmodule

// File: tb/tb_pulse_stretcher_mc.sv
// Directed, table-driven bench for pulse_stretcher_mc (CH=4, CNT_W=8).
module tb_pulse_stretcher_mc;

    logic       clk;
    logic       rst;
    logic [3:0] pin;
    logic [7:0] stretch_len;
    logic       retrig;
    logic [3:0] pout;
    logic [3:0] done;
    logic       busy;

    int vectors;
    int miscompares;

    typedef struct {
        logic [3:0] pin;
        logic [7:0] len;
        logic       retrig;
        logic [3:0] exp_pout;
        logic [3:0] exp_done;
    } vec_t;

    vec_t vecs[$];

    pulse_stretcher_mc #(
        .CH    (4),
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pin         (pin),
        .stretch_len (stretch_len),
        .retrig      (retrig),
        .pout        (pout),
        .done        (done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic [3:0] p, input logic [7:0] l, input logic r,
                                input logic [3:0] ep, input logic [3:0] ed);
        vec_t v;
        v.pin = p; v.len = l; v.retrig = r; v.exp_pout = ep; v.exp_done = ed;
        vecs.push_back(v);
    endfunction

    // Drive inputs, let one rising edge pass, then settle 1 time unit after it.
    task automatic step(input logic [3:0] p, input logic [7:0] l, input logic r);
        pin = p; stretch_len = l; retrig = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [3:0] ep, input logic [3:0] ed);
        vectors++;
        if (pout !== ep || done !== ed || busy !== (|ep)) begin
            miscompares++;
            $display("FAIL %s: pout=%b done=%b busy=%b, expected pout=%b done=%b busy=%b",
                     name, pout, done, busy, ep, ed, |ep);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int hi;
        bit seen;
        vectors = 0;
        miscompares = 0;
        rst = 1'b0; pin = '0; stretch_len = 8'd3; retrig = 1'b0;

        // Basic, len 3, one-cycle pin pulse
        add(4'b0001, 8'd3, 1'b0, 4'b0001, 4'b0000);
        add(4'b0000, 8'd3, 1'b0, 4'b0001, 4'b0000);
        add(4'b0000, 8'd3, 1'b0, 4'b0001, 4'b0000);
        add(4'b0000, 8'd3, 1'b0, 4'b0000, 4'b0001);
        add(4'b0000, 8'd3, 1'b0, 4'b0000, 4'b0000);
        // Retrigger, len 4, rises at k and k+2 -> 6 cycles
        add(4'b0001, 8'd4, 1'b1, 4'b0001, 4'b0000);
        add(4'b0000, 8'd4, 1'b1, 4'b0001, 4'b0000);
        add(4'b0001, 8'd4, 1'b1, 4'b0001, 4'b0000);
        add(4'b0000, 8'd4, 1'b1, 4'b0001, 4'b0000);
        add(4'b0000, 8'd4, 1'b1, 4'b0001, 4'b0000);
        add(4'b0000, 8'd4, 1'b1, 4'b0001, 4'b0000);
        add(4'b0000, 8'd4, 1'b1, 4'b0000, 4'b0001);
        add(4'b0000, 8'd4, 1'b1, 4'b0000, 4'b0000);
        // Same stimulus, non-retriggerable -> 4 cycles
        add(4'b0001, 8'd4, 1'b0, 4'b0001, 4'b0000);
        add(4'b0000, 8'd4, 1'b0, 4'b0001, 4'b0000);
        add(4'b0001, 8'd4, 1'b0, 4'b0001, 4'b0000);
        add(4'b0000, 8'd4, 1'b0, 4'b0001, 4'b0000);
        add(4'b0000, 8'd4, 1'b0, 4'b0000, 4'b0001);
        add(4'b0000, 8'd4, 1'b0, 4'b0000, 4'b0000);
        // Final-cycle collision, len 2, retrig=1
        add(4'b0001, 8'd2, 1'b1, 4'b0001, 4'b0000);
        add(4'b0000, 8'd2, 1'b1, 4'b0001, 4'b0000);
        add(4'b0001, 8'd2, 1'b1, 4'b0001, 4'b0000);
        add(4'b0000, 8'd2, 1'b1, 4'b0001, 4'b0000);
        add(4'b0000, 8'd2, 1'b1, 4'b0000, 4'b0001);
        add(4'b0000, 8'd2, 1'b1, 4'b0000, 4'b0000);
        // Final-cycle collision, len 2, retrig=0
        add(4'b0001, 8'd2, 1'b0, 4'b0001, 4'b0000);
        add(4'b0000, 8'd2, 1'b0, 4'b0001, 4'b0000);
        add(4'b0001, 8'd2, 1'b0, 4'b0000, 4'b0001);
        add(4'b0000, 8'd2, 1'b0, 4'b0000, 4'b0000);
        // Zero length behaves as one cycle
        add(4'b0001, 8'd0, 1'b0, 4'b0001, 4'b0000);
        add(4'b0000, 8'd0, 1'b0, 4'b0000, 4'b0001);
        add(4'b0000, 8'd0, 1'b0, 4'b0000, 4'b0000);
        // Pin held 10 cycles, len 2 -> only 2 cycles
        add(4'b0001, 8'd2, 1'b0, 4'b0001, 4'b0000);
        add(4'b0001, 8'd2, 1'b0, 4'b0001, 4'b0000);
        add(4'b0001, 8'd2, 1'b0, 4'b0000, 4'b0001);
        for (int i = 0; i < 7; i++) add(4'b0001, 8'd2, 1'b0, 4'b0000, 4'b0000);
        add(4'b0000, 8'd2, 1'b0, 4'b0000, 4'b0000);
        // Length changed to 9 mid-window; next trigger uses 9
        add(4'b0001, 8'd3, 1'b0, 4'b0001, 4'b0000);
        add(4'b0000, 8'd9, 1'b0, 4'b0001, 4'b0000);
        add(4'b0000, 8'd9, 1'b0, 4'b0001, 4'b0000);
        add(4'b0000, 8'd9, 1'b0, 4'b0000, 4'b0001);
        add(4'b0001, 8'd9, 1'b0, 4'b0001, 4'b0000);
        for (int i = 0; i < 8; i++) add(4'b0000, 8'd9, 1'b0, 4'b0001, 4'b0000);
        add(4'b0000, 8'd9, 1'b0, 4'b0000, 4'b0001);
        add(4'b0000, 8'd9, 1'b0, 4'b0000, 4'b0000);
        // Channel independence: ch1 at k, ch3 at k+1, len 3
        add(4'b0010, 8'd3, 1'b0, 4'b0010, 4'b0000);
        add(4'b1000, 8'd3, 1'b0, 4'b1010, 4'b0000);
        add(4'b0000, 8'd3, 1'b0, 4'b1010, 4'b0000);
        add(4'b0000, 8'd3, 1'b0, 4'b1000, 4'b0010);
        add(4'b0000, 8'd3, 1'b0, 4'b0000, 4'b1000);
        add(4'b0000, 8'd3, 1'b0, 4'b0000, 4'b0000);
        // Simultaneous rises on all channels, len 1
        add(4'b1111, 8'd1, 1'b0, 4'b1111, 4'b0000);
        add(4'b0000, 8'd1, 1'b0, 4'b0000, 4'b1111);
        add(4'b0000, 8'd1, 1'b0, 4'b0000, 4'b0000);

        // Reset state, including across clock edges
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", 4'b0000, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_out("post_release_idle", 4'b0000, 4'b0000);

        foreach (vecs[i]) begin
            step(vecs[i].pin, vecs[i].len, vecs[i].retrig);
            check_out($sformatf("vec%0d", i), vecs[i].exp_pout, vecs[i].exp_done);
        end

        // Length 255: count high cycles up to the done pulse, bounded
        step(4'b0001, 8'd255, 1'b0);
        hi = 0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (pout[0]) hi++;
            if (done[0]) seen = 1'b1;
            else step(4'b0000, 8'd255, 1'b0);
        end
        check_val("len255_high_cycles", hi, 255);
        check_val("len255_done_seen", int'(seen), 1);
        step(4'b0000, 8'd5, 1'b0);
        check_out("len255_after", 4'b0000, 4'b0000);

        // Reset mid-stretch, len 5: outputs drop without a clock edge, no done
        step(4'b0001, 8'd5, 1'b0);
        step(4'b0000, 8'd5, 1'b0);
        check_out("pre_reset_active", 4'b0001, 4'b0000);
        #2;
        rst = 1'b0;
        pin = 4'b0001;
        #1;
        check_out("async_reset_drop", 4'b0000, 4'b0000);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_out("in_reset_no_done", 4'b0000, 4'b0000);
        end
        @(negedge clk);
        rst = 1'b1;
        // Pin still high at release: retriggers on the first edge for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step(4'b0001, 8'd5, 1'b0);
            check_out($sformatf("rerelease_hi%0d", i), 4'b0001, 4'b0000);
        end
        step(4'b0001, 8'd5, 1'b0);
        check_out("rerelease_done", 4'b0000, 4'b0001);
        step(4'b0000, 8'd5, 1'b0);
        check_out("rerelease_idle", 4'b0000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
